hazard_stall_controller: RTL

//  Pipeline sequencer in the 5-stage RISC core: decides each cycle whether fetch/decode advance, stall,
//  or get squashed. Covers load-use hazards the operand forwarding network cannot resolve, taken-branch

---
 rtl/hazard_stall_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_controller
// Purpose  : 5-stage pipeline sequencer. Handles load-use stalls, branch
//            flushes, memory freezes and the interrupt entry sequence.
// Revision : 1.0
// ============================================================================
module hazard_stall_controller #(
    parameter int ADDR_W       = 3,
    parameter int LOAD_STALL   = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int INT_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] id_rsrc_addr,
    input  logic [ADDR_W-1:0] id_rdst_addr,
    input  logic              id_uses_rsrc,
    input  logic              id_uses_rdst,
    input  logic [ADDR_W-1:0] ex_rdst_addr,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic              ex_branch_taken,
    input  logic              mem_busy,
    input  logic              int_req,
    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              int_save_en,
    output logic              pc_sel_vector,
    output logic              int_ack,
    output logic [2:0]        state_dbg,
    output logic [15:0]       stall_cycles
);

    localparam int C_MAX_A = (LOAD_STALL > DRAIN_CYCLES) ? LOAD_STALL : DRAIN_CYCLES;
    localparam int C_MAX   = (C_MAX_A > INT_CYCLES) ? C_MAX_A : INT_CYCLES;
    localparam int CNT_W   = (C_MAX <= 2) ? 1 : $clog2(C_MAX);

    localparam logic [CNT_W-1:0] C_LD_INIT  = CNT_W'((LOAD_STALL > 1) ? LOAD_STALL - 2 : 0);
    localparam logic [CNT_W-1:0] C_DR_INIT  = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_INT_INIT = CNT_W'(INT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RUN       = 3'd0,
        S_LOAD_WAIT = 3'd1,
        S_INT_DRAIN = 3'd2,
        S_INT_SAVE  = 3'd3,
        S_INT_VEC   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [15:0]      r_stall;
    logic             w_load_use;
    logic             w_cnt_zero;

    assign w_load_use = ex_mem_read & ex_reg_write &
                        ((id_uses_rsrc & (id_rsrc_addr == ex_rdst_addr)) |
                         (id_uses_rdst & (id_rdst_addr == ex_rdst_addr)));
    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        int_save_en   = 1'b0;
        pc_sel_vector = 1'b0;
        int_ack       = 1'b0;
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        if (rst) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
        end else if (mem_busy) begin
            // Whole pipe frozen: nothing moves, sequence position is held.
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (w_load_use) begin
                        pc_write_en   = 1'b0;
                        ifid_write_en = 1'b0;
                        idex_bubble   = 1'b1;
                        if (LOAD_STALL > 1) begin
                            w_next_cnt   = C_LD_INIT;
                            w_next_state = S_LOAD_WAIT;
                        end
                    end else if (int_req) begin
                        w_next_cnt   = C_DR_INIT;
                        w_next_state = S_INT_DRAIN;
                    end
                end
                S_LOAD_WAIT: begin
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    idex_bubble   = 1'b1;
                    w_next_cnt    = r_cnt - CNT_W'(1);
                    if (w_cnt_zero) w_next_state = S_RUN;
                end
                S_INT_DRAIN: begin
                    // A branch resolving while draining redirects the PC so the saved PC is the target.
                    pc_write_en   = ex_branch_taken;
                    ifid_write_en = 1'b0;
                    ifid_flush    = 1'b1;
                    idex_bubble   = 1'b1;
                    w_next_cnt    = r_cnt - CNT_W'(1);
                    if (w_cnt_zero) begin
                        w_next_cnt   = C_INT_INIT;
                        w_next_state = S_INT_SAVE;
                    end
                end
                S_INT_SAVE: begin
                    int_save_en   = 1'b1;
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    ifid_flush    = 1'b1;
                    idex_bubble   = 1'b1;
                    w_next_cnt    = r_cnt - CNT_W'(1);
                    if (w_cnt_zero) w_next_state = S_INT_VEC;
                end
                S_INT_VEC: begin
                    pc_sel_vector = 1'b1;
                    int_ack       = 1'b1;
                    ifid_write_en = 1'b0;
                    ifid_flush    = 1'b1;
                    idex_bubble   = 1'b1;
                    w_next_state  = S_RUN;
                end
                default: begin
                    w_next_state = S_RUN;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_stall <= 16'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (!pc_write_en && (r_stall != 16'hFFFF)) r_stall <= r_stall + 16'd1;
        end
    end

    assign state_dbg    = r_state;
    assign stall_cycles = r_stall;

endmodule
`default_nettype wire
